cordic_vector: RTL and testbench
================================

CORDIC_VECTOR -- requirements
Module: cordic_vector

Interface
REQ-001 SHALL have no parameters; iteration count fixed at 14, data width fixed at 16.
REQ-002 i_clk  input  1  sole clock; all state updates on rising edge.
REQ-003 i_rst_n  input  1  reset, asynchronous, active-low.
REQ-004 i_start  input  1  request; sampled only in IDLE.
REQ-005 i_x  input  16  signed two's complement, Q2.14.
REQ-006 i_y  input  16  signed two's complement, Q2.14.
REQ-007 o_angle  output  16  atan2(y,x), signed Q3.13 radians, range -pi..+pi.
REQ-008 o_mag  output  16  sqrt(x^2+y^2), unsigned Q2.14, saturating.
REQ-009 o_busy  output  1  high while a computation is in progress.
REQ-010 o_done  output  1  one-cycle pulse; o_angle/o_mag valid.

Function
REQ-011 FSM states: IDLE, PRE, ITER, POST, DONE.
REQ-012 IDLE -> PRE when i_start=1 at a rising edge; i_x/i_y captured on that edge.
REQ-013 PRE: sign-extend to 20-bit internal x,y,z.
- x>=0: no fold, z=0.
- x<0, y>=0: (x,y) <- (y,-x), z=+pi/2 (0x3244).
- x<0, y<0: (x,y) <- (-y,x), z=-pi/2 (0xCDBC).
REQ-014 ITER: 14 cycles, i=0..13; d=+1 if y<0 else -1; x <- x - d*(y>>>i); y <- y + d*(x>>>i); z <- z - d*atan(2^-i), using arithmetic shifts.
REQ-015 atan(2^-i) held in a 14-entry constant table, Q3.13, rounded to nearest.
REQ-016 POST: gain handling per REQ-027/028; magnitude clamped to [0, 0xFFFF]; angle truncated to 16 bits.
REQ-017 DONE: o_done=1 for exactly one cycle, then IDLE.
REQ-018 Latency: o_done high in the 17th cycle after the edge sampling i_start; constant for all inputs.
REQ-019 o_busy=1 in PRE, ITER, POST; 0 in IDLE and DONE.
REQ-020 i_start while not IDLE is ignored; captured operands unaffected.
REQ-021 o_angle/o_mag update only on POST->DONE; held until the next completion.
REQ-022 i_start held high across DONE starts a new computation on the IDLE cycle that follows (back-to-back throughput: 18 cycles).
REQ-023 x=y=0: o_angle=0, o_mag=0.
REQ-024 i_x=0x8000 handled without overflow (20-bit internal); (-2.0,0) gives o_angle=+pi (0x6488) +/-2 LSB.
REQ-025 Accuracy: o_angle within +/-2 LSB, o_mag within +/-4 LSB of the ideal value for unsaturated results.

Reset
REQ-026 While i_rst_n=0: state=IDLE, o_angle=0, o_mag=0, o_busy=0, o_done=0, internal registers cleared; asserting i_rst_n low mid-computation aborts it with no o_done pulse; the first accepted i_start after release proceeds normally.

Configuration
REQ-027 CORDIC_VECTOR_GAIN_COMP_EN defined: POST multiplies final x by 1/K = 0x26DD (Q1.14) and rounds, so o_mag = true magnitude.
REQ-028 CORDIC_VECTOR_GAIN_COMP_EN undefined: no multiplier; o_mag = raw x (approx. 1.6468 * magnitude), saturated. Latency identical in both builds.

Verification
REQ-029 Gain comp on: x=0x4000, y=0x0000 -> o_angle=0x0000 +/-2, o_mag=0x4000 +/-4, o_done at cycle 17.
REQ-030 Gain comp on: x=0x4000, y=0x4000 -> o_angle=0x1922 +/-2, o_mag=0x5A82 +/-4.
REQ-031 x=0xC000, y=0x0000 -> o_angle=0x6488 +/-2; x=0x0000, y=0xC000 -> o_angle=0xCDBC +/-2.
REQ-032 Gain comp off: x=0x4000, y=0x0000 -> o_mag=0x6965 +/-4; x=y=0x7FFF -> o_mag=0xFFFF (saturated).
REQ-033 i_start pulsed again at cycle 5 of a run -> ignored, single o_done with the first operands' result; i_rst_n low at cycle 8 -> outputs 0, no o_done, next start completes correctly.
REQ-034 Sweep: angles 0..0x6486 step 0x40 on a radius-1.0 circle -> every result within REQ-025 tolerance.

Source files
------------

// File: rtl/cordic_vector.sv
// cordic_vector: 14-iteration CORDIC vectoring unit producing atan2(y,x) and magnitude.
// Define CORDIC_VECTOR_GAIN_COMP_EN to scale the magnitude by 1/K; otherwise the raw gained x is output.
module cordic_vector (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_start,
  input  logic [15:0] i_x,
  input  logic [15:0] i_y,
  output logic [15:0] o_angle,
  output logic [15:0] o_mag,
  output logic        o_busy,
  output logic        o_done
);
  typedef enum logic [2:0] {IDLE, PRE, ITER, POST, DONE} state_t;
  state_t state;
  logic signed [19:0] x, y, xs, ys, x_nx, y_nx;
  logic signed [15:0] z, z_nx, atan_i;
  logic signed [35:0] xe, mag_full;
  logic [15:0] mag_sat;
  logic [3:0] iter;
  logic zero, neg;
  always_comb begin
    case (iter)
      4'd0:    atan_i = 16'sd6434;
      4'd1:    atan_i = 16'sd3798;
      4'd2:    atan_i = 16'sd2007;
      4'd3:    atan_i = 16'sd1019;
      4'd4:    atan_i = 16'sd511;
      4'd5:    atan_i = 16'sd256;
      4'd6:    atan_i = 16'sd128;
      4'd7:    atan_i = 16'sd64;
      4'd8:    atan_i = 16'sd32;
      4'd9:    atan_i = 16'sd16;
      4'd10:   atan_i = 16'sd8;
      4'd11:   atan_i = 16'sd4;
      4'd12:   atan_i = 16'sd2;
      4'd13:   atan_i = 16'sd1;
      default: atan_i = 16'sd0;
    endcase
  end
  // d = +1 when y is negative: rotate toward the x axis
  assign neg  = y[19];
  assign xs   = x >>> iter;
  assign ys   = y >>> iter;
  assign x_nx = neg ? x - ys : x + ys;
  assign y_nx = neg ? y + xs : y - xs;
  assign z_nx = neg ? z - atan_i : z + atan_i;
  assign xe   = 36'(x);
`ifdef CORDIC_VECTOR_GAIN_COMP_EN
  assign mag_full = (xe * 36'sd9949 + 36'sd8192) >>> 14;
`else
  assign mag_full = xe;
`endif
  assign mag_sat = mag_full[35] ? 16'd0 : (|mag_full[34:16]) ? 16'hFFFF : mag_full[15:0];
  // z stays within about +/-1.1*pi in Q3.13, so 16 bits hold it exactly
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      state   <= IDLE;
      x       <= '0;
      y       <= '0;
      z       <= '0;
      iter    <= '0;
      zero    <= 1'b0;
      o_angle <= '0;
      o_mag   <= '0;
      o_busy  <= 1'b0;
      o_done  <= 1'b0;
    end else
      case (state)
        IDLE: if (i_start) begin
          x      <= {{4{i_x[15]}}, i_x};
          y      <= {{4{i_y[15]}}, i_y};
          zero   <= ~|{i_x, i_y};
          o_busy <= 1'b1;
          state  <= PRE;
        end
        PRE: begin
          if (!x[19]) z <= '0;
          else if (!y[19]) begin
            x <= y;
            y <= -x;
            z <= 16'sh3244;
          end else begin
            x <= -y;
            y <= x;
            z <= 16'shCDBC;
          end
          iter  <= '0;
          state <= ITER;
        end
        ITER: begin
          x     <= x_nx;
          y     <= y_nx;
          z     <= z_nx;
          iter  <= iter + 4'd1;
          state <= (iter == 4'd13) ? POST : ITER;
        end
        POST: begin
          o_angle <= zero ? 16'd0 : z;
          o_mag   <= mag_sat;
          o_busy  <= 1'b0;
          o_done  <= 1'b1;
          state   <= DONE;
        end
        DONE: begin
          o_done <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
endmodule

// File: tb/tb_cordic_vector.sv
// tb_cordic_vector: table, corner-sequence, sweep and random checks of cordic_vector against a real-arithmetic model.
module tb_cordic_vector;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic [15:0] xin = '0, yin = '0;
  logic [15:0] angle, mag;
  logic busy, done;
`ifdef CORDIC_VECTOR_GAIN_COMP_EN
  localparam bit GAIN = 1'b1;
`else
  localparam bit GAIN = 1'b0;
`endif
  // raw output carries the CORDIC gain, so the true-magnitude band widens with it
  localparam int MAG_TOL = GAIN ? 4 : 7;
  typedef struct {
    logic [15:0] x, y, ang, mag_on, mag_off;
  } vec_t;
  vec_t tbl [10];
  int n_vec = 0, n_err = 0;
  real kgain = 1.0;

  always #5 clk = ~clk;

  cordic_vector dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_x(xin), .i_y(yin),
    .o_angle(angle), .o_mag(mag), .o_busy(busy), .o_done(done)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int got, input int exp, input int tol);
    n_vec++;
    if (got - exp > tol || exp - got > tol) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d +/- %0d", name, got, exp, tol);
    end
  endtask

  task automatic check_ang(input string name, input logic [15:0] got, input int exp, input int tol);
    int g;
    g = int'($signed(got));
    if (g - exp > 25736) g -= 51472;
    else if (exp - g > 25736) g += 51472;
    check(name, g, exp, tol);
  endtask

  function automatic int ref_ang(input logic [15:0] x, input logic [15:0] y);
    if (x == 16'd0 && y == 16'd0) return 0;
    return int'($atan2($itor($signed(y)), $itor($signed(x))) * 8192.0);
  endfunction

  function automatic int ref_mag(input logic [15:0] x, input logic [15:0] y);
    real xr, yr, m;
    xr = $itor($signed(x));
    yr = $itor($signed(y));
    m = $sqrt(xr * xr + yr * yr) * (GAIN ? 1.0 : kgain);
    return (m > 65535.0) ? 65535 : int'(m);
  endfunction

  task automatic run(input logic [15:0] x, input logic [15:0] y, output int lat,
                     output logic [15:0] a, output logic [15:0] m);
    xin = x;
    yin = y;
    start = 1'b1;
    tick();
    start = 1'b0;
    lat = 1;
    while (!done && lat < 40) begin
      tick();
      lat++;
    end
    a = angle;
    m = mag;
    tick();
  endtask

  task automatic run_check(input string name, input logic [15:0] x, input logic [15:0] y,
                           input int ea, input int em);
    int lat;
    logic [15:0] a, m;
    bit z;
    z = (x == 16'd0 && y == 16'd0);
    run(x, y, lat, a, m);
    check({name, " latency"}, lat, 17, 0);
    check_ang({name, " angle"}, a, ea, z ? 0 : 2);
    check({name, " mag"}, int'(m), em, (z || (!GAIN && em == 65535)) ? 0 : MAG_TOL);
  endtask

  initial begin
    int lat, nd;
    logic [15:0] a, m;
    for (int i = 0; i < 14; i++) kgain *= $sqrt(1.0 + 1.0 / (4.0 ** i));
    tbl = '{
      '{16'h4000, 16'h0000, 16'h0000, 16'h4000, 16'h6965},
      '{16'h4000, 16'h4000, 16'h1922, 16'h5A82, 16'h950C},
      '{16'hC000, 16'h0000, 16'h6488, 16'h4000, 16'h6965},
      '{16'h0000, 16'hC000, 16'hCDBC, 16'h4000, 16'h6965},
      '{16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000},
      '{16'h8000, 16'h0000, 16'h6488, 16'h8000, 16'hD2C9},
      '{16'h7FFF, 16'h7FFF, 16'h1922, 16'hB504, 16'hFFFF},
      '{16'h0000, 16'h4000, 16'h3244, 16'h4000, 16'h6965},
      '{16'h8000, 16'h8000, 16'hB49A, 16'hB505, 16'hFFFF},
      '{16'hC000, 16'h4000, 16'h4B66, 16'h5A82, 16'h950C}
    };
    repeat (3) tick();
    check("reset angle", int'(angle), 0, 0);
    check("reset mag", int'(mag), 0, 0);
    check("reset busy", int'(busy), 0, 0);
    check("reset done", int'(done), 0, 0);
    rst_n = 1'b1;
    tick();

    xin = 16'h4000;
    yin = 16'h0000;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("busy in PRE", int'(busy), 1, 0);
    lat = 1;
    while (!done && lat < 40) begin
      tick();
      lat++;
    end
    check("first latency", lat, 17, 0);
    check("busy in DONE", int'(busy), 0, 0);
    tick();
    check("done width", int'(done), 0, 0);

    for (int i = 0; i < 10; i++)
      run_check($sformatf("table[%0d]", i), tbl[i].x, tbl[i].y, int'($signed(tbl[i].ang)),
                int'(GAIN ? tbl[i].mag_on : tbl[i].mag_off));

    xin = 16'h4000;
    yin = 16'h0000;
    start = 1'b1;
    tick();
    lat = 1;
    while (!done && lat < 40) begin
      tick();
      lat++;
    end
    check("b2b first latency", lat, 17, 0);
    xin = 16'h0000;
    yin = 16'h4000;
    lat = 0;
    do begin
      tick();
      lat++;
      if (lat == 10) check_ang("held angle", angle, 0, 2);
    end while (!done && lat < 40);
    start = 1'b0;
    check("b2b spacing", lat, 18, 0);
    check_ang("b2b angle", angle, 12868, 2);
    check("b2b mag", int'(mag), GAIN ? 16384 : 26981, MAG_TOL);
    tick();

    xin = 16'h4000;
    yin = 16'h4000;
    start = 1'b1;
    tick();
    start = 1'b0;
    lat = 1;
    while (!done && lat < 40) begin
      if (lat == 5) begin
        start = 1'b1;
        xin = 16'hC000;
        yin = 16'h0000;
      end
      tick();
      start = 1'b0;
      lat++;
    end
    check("restart-ignored latency", lat, 17, 0);
    check_ang("restart-ignored angle", angle, 6434, 2);
    check("restart-ignored mag", int'(mag), GAIN ? 23170 : 38156, MAG_TOL);
    nd = 0;
    repeat (25) begin
      tick();
      if (done) nd++;
    end
    check("no extra done", nd, 0, 0);

    xin = 16'h4000;
    yin = 16'h4000;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (7) tick();
    rst_n = 1'b0;
    #1;
    check("abort angle", int'(angle), 0, 0);
    check("abort mag", int'(mag), 0, 0);
    check("abort busy", int'(busy), 0, 0);
    check("abort done", int'(done), 0, 0);
    tick();
    tick();
    rst_n = 1'b1;
    nd = 0;
    repeat (25) begin
      tick();
      if (done) nd++;
    end
    check("no done after abort", nd, 0, 0);
    run_check("after abort", 16'h0000, 16'h4000, 12868, GAIN ? 16384 : 26981);

    for (int ang = 0; ang <= 16'h6486; ang += 64) begin
      logic [15:0] sx, sy;
      sx = 16'(int'($cos(ang / 8192.0) * 16384.0));
      sy = 16'(int'($sin(ang / 8192.0) * 16384.0));
      run_check("sweep", sx, sy, ref_ang(sx, sy), ref_mag(sx, sy));
    end

    for (int i = 0; i < 80; i++) begin
      logic [15:0] rx, ry;
      real r;
      do begin
        rx = 16'($urandom);
        ry = 16'($urandom);
        r = $sqrt($itor($signed(rx)) ** 2 + $itor($signed(ry)) ** 2) / 16384.0;
      end while (r < 1.0 || r > 1.95);
      run_check("random", rx, ry, ref_ang(rx, ry), ref_mag(rx, ry));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
